// File: rtl/io_input_port_pkg.sv
// Shared machine IO package: default bus width, debounce timing and the
// debounce FSM state encoding used by the input port and its debouncer.
package io_input_port_pkg;

    localparam int DATA_W_DEFAULT    = 8;
    localparam int DB_CYCLES_DEFAULT = 1000000;

    typedef logic [1:0] db_state_t;

    localparam logic [1:0] ST_LOW      = 2'd0;
    localparam logic [1:0] ST_CHK_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_CHK_LOW  = 2'd3;

    // Debounced level is high while pressed or while a release is being confirmed.
    function automatic logic db_level(input db_state_t st);
        db_level = (st == ST_HIGH) || (st == ST_CHK_LOW);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus four-state debouncer for the capture button.
// Emits a single-cycle capture strobe when a press has been confirmed.
module btn_debounce
    import io_input_port_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic capture
);

    localparam int                 CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(1'b0);

    logic             sync1_r;
    logic             sync2_r;
    db_state_t        state_r;
    db_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             capture_s;
    logic             btn_db_r;

    // Bring the raw button into the clock domain before any decision uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and capture strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (sync2_r) begin
                    state_nxt_s = ST_CHK_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_LOW;
                end
            end
            ST_CHK_HIGH: begin
                if (!sync2_r) begin
                    state_nxt_s = ST_LOW;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = ST_HIGH;
                    capture_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync2_r) begin
                    state_nxt_s = ST_CHK_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_HIGH;
                end
            end
            ST_CHK_LOW: begin
                // A bounce back to 1 while confirming a release keeps the press.
                if (sync2_r) begin
                    state_nxt_s = ST_HIGH;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = ST_LOW;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_LOW;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, counter and registered debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_LOW;
            cnt_r    <= CNT_ZERO;
            btn_db_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            btn_db_r <= db_level(state_nxt_s);
        end
    end

    assign btn_db  = btn_db_r;
    assign capture = capture_s;

endmodule

// File: rtl/io_input_port.sv
// Switch input port: synchronizes the switch bus, debounces the capture
// button and holds the captured word with valid/overrun bookkeeping.
module io_input_port
    import io_input_port_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btnS,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun,
    output logic              btn_db
);

    localparam logic [DATA_W-1:0] WORD_ZERO = DATA_W'(1'b0);

    logic [DATA_W-1:0] sw_sync1_r;
    logic [DATA_W-1:0] sw_sync2_r;
    logic              capture_s;
    logic              read_s;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              overrun_r;

    // Two-flop synchronizer for the switch bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_r <= WORD_ZERO;
            sw_sync2_r <= WORD_ZERO;
        end else begin
            sw_sync1_r <= sw;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btnS),
        .btn_db  (btn_db),
        .capture (capture_s)
    );

    // A read only counts while there is an unread word to consume.
    assign read_s = rd_en && valid_r;

    // Capture register: a capture that coincides with a read is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= WORD_ZERO;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (capture_s) begin
                data_r  <= sw_sync2_r;
                valid_r <= 1'b1;
            end else if (read_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            if (capture_s && valid_r && !rd_en) begin
                overrun_r <= 1'b1;
            end else if (read_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign data_out   = data_r;
    assign data_valid = valid_r;
    assign overrun    = overrun_r;

endmodule

// File: doc/io_input_port.md
IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of switch bus and captured word.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, stable-input cycles required to accept a button level change (10 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sw  input  DATA_W  raw board switches, asynchronous to clk.
REQ-006 SHALL have port btnS  input  1  raw capture pushbutton, asynchronous, bouncy.
REQ-007 SHALL have port rd_en  input  1  one-cycle read strobe from the machine's IN operation.
REQ-008 SHALL have port data_out  output  DATA_W  last captured switch word.
REQ-009 SHALL have port data_valid  output  1  unread word present in data_out.
REQ-010 SHALL have port overrun  output  1  sticky flag: a capture replaced an unread word.
REQ-011 SHALL have port btn_db  output  1  debounced button level.

Function
REQ-012 SHALL pass sw and btnS each through a two-flop synchronizer before any other use; input-to-internal latency is 2 cycles.
REQ-013 SHALL debounce with FSM states LOW, CHK_HIGH, HIGH, CHK_LOW and a counter of width clog2(DB_CYCLES+1).
REQ-014 SHALL transition LOW->CHK_HIGH when the synced button is 1, clearing the counter.
REQ-015 SHALL, in CHK_HIGH, return to LOW if the synced button drops to 0 before the count reaches DB_CYCLES, else enter HIGH when the count equals DB_CYCLES.
REQ-016 SHALL handle HIGH->CHK_LOW->LOW symmetrically; a bounce in CHK_LOW returns to HIGH.
REQ-017 SHALL drive btn_db 1 exactly in states HIGH and CHK_LOW.
REQ-018 SHALL generate a one-cycle capture pulse on the CHK_HIGH->HIGH transition only; no capture on release.
REQ-019 SHALL, on the cycle after the capture pulse, load data_out with the synchronized sw value sampled during the capture cycle and set data_valid.
REQ-020 SHALL clear data_valid on the cycle after rd_en when data_valid is 1; data_out holds its value.
REQ-021 SHALL ignore rd_en when data_valid is 0 (no state change).
REQ-022 SHALL set overrun when capture occurs while data_valid is 1 and rd_en is 0; the new word overwrites data_out.
REQ-023 SHALL, on simultaneous capture and rd_en, load the new word, keep data_valid 1, and not set overrun.
REQ-024 SHALL clear overrun on any rd_en (priority over setting in the same cycle is given to set).
REQ-025 SHALL saturate the debounce counter at DB_CYCLES, never wrap.

Reset
REQ-026 SHALL, while rst_n is 0, force FSM to LOW, counter 0, synchronizers 0, data_out 0, data_valid 0, overrun 0, btn_db 0.
REQ-027 SHALL, on reset asserted mid-debounce or with an unread word, discard both; a button held through reset release requires a full DB_CYCLES before capture.

Structure
REQ-028 SHALL place the debounce state encoding and the default DATA_W in the shared machine IO package.
REQ-029 SHALL implement the synchronizer+FSM as sub-module btn_debounce, instantiated once; the capture register lives in io_input_port.

Verification (bench sets DB_CYCLES=4)
REQ-030 SHALL verify: sw=8'h03, clean btnS press held 10 cycles -> data_out=8'h03, data_valid=1 at cycle 2+5+1 after press edge.
REQ-031 SHALL verify: btnS bouncing 1,0,1,0 at 2-cycle spacing then stable 1 -> exactly one capture, overrun=0.
REQ-032 SHALL verify: capture 8'h04, no read, release, capture 8'h07 -> data_out=8'h07, overrun=1; rd_en -> data_valid=0, overrun=0 next cycle.
REQ-033 SHALL verify: rd_en in same cycle as capture of 8'h05 -> data_out=8'h05, data_valid=1, overrun=0.
REQ-034 SHALL verify: rst_n pulled low while in CHK_HIGH with btnS held, released -> no capture until 4 further stable cycles; all outputs 0 during reset.
REQ-035 SHALL verify: rd_en with data_valid=0 -> data_out, data_valid, overrun unchanged.
